// File: rtl/dual_issue_scheduler.sv
// In-order instruction-pair queue feeding two issue lanes. The head pair issues
// together unless the younger instruction depends on the older one or stall is high.
module dual_issue_scheduler #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fetch_valid_i,
    input  logic [31:0]              fetch_inst0_i,
    input  logic [31:0]              fetch_inst1_i,
    input  logic [31:0]              fetch_pc_i,
    output logic                     fetch_ready_o,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic                     issue0_valid_o,
    output logic [31:0]              issue0_inst_o,
    output logic [31:0]              issue0_pc_o,
    output logic                     issue1_valid_o,
    output logic [31:0]              issue1_inst_o,
    output logic [31:0]              issue1_pc_o,
    output logic [$clog2(DEPTH):0]   queue_count_o
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_ALUR = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             enq;
    logic [1:0]       deq_num;
    logic [PTR_W-1:0] head_p1;
    logic [31:0]      h0;
    logic [31:0]      h1;
    logic [31:0]      h0_pc;
    logic [31:0]      h1_pc;
    logic             h0_writes;
    logic             h1_writes;
    logic             h1_reads_rs1;
    logic             h1_reads_rs2;
    logic             hazard;

    function automatic logic op_writes(input logic [6:0] op);
        return (op == OP_ALUI) || (op == OP_ALUR) || (op == OP_LUI);
    endfunction

    assign fetch_ready_o = (count <= CNT_W'(DEPTH - 2));
    assign enq           = fetch_valid_i && fetch_ready_o;
    assign queue_count_o = count;

    always_comb begin
        head_p1      = head + PTR_W'(1);
        h0           = inst_q[head];
        h1           = inst_q[head_p1];
        h0_pc        = pc_q[head];
        h1_pc        = pc_q[head_p1];
        // A write to x0 is architecturally void, so it never creates a hazard.
        h0_writes    = op_writes(h0[6:0]) && (h0[11:7] != 5'd0);
        h1_writes    = op_writes(h1[6:0]) && (h1[11:7] != 5'd0);
        h1_reads_rs1 = (h1[6:0] == OP_ALUI) || (h1[6:0] == OP_ALUR);
        h1_reads_rs2 = (h1[6:0] == OP_ALUR);
        hazard       = 1'b0;
        if (h0_writes) begin
            if (h1_reads_rs1 && (h1[19:15] == h0[11:7])) hazard = 1'b1;
            if (h1_reads_rs2 && (h1[24:20] == h0[11:7])) hazard = 1'b1;
            if (h1_writes && (h1[11:7] == h0[11:7]))     hazard = 1'b1;
        end
        deq_num = 2'd0;
        if (!stall_i && !flush_i) begin
            if (count == CNT_W'(1))      deq_num = 2'd1;
            else if (count > CNT_W'(1))  deq_num = hazard ? 2'd1 : 2'd2;
        end
    end

    // Storage has no reset; occupancy tracking guards every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && enq) begin
            inst_q[tail]              <= fetch_inst0_i;
            pc_q[tail]                <= fetch_pc_i;
            inst_q[tail + PTR_W'(1)]  <= fetch_inst1_i;
            pc_q[tail + PTR_W'(1)]    <= fetch_pc_i + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            issue0_valid_o <= 1'b0;
            issue0_inst_o  <= NOP;
            issue0_pc_o    <= RESET_PC;
            issue1_valid_o <= 1'b0;
            issue1_inst_o  <= NOP;
            issue1_pc_o    <= RESET_PC;
        end else if (flush_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            issue0_valid_o <= 1'b0;
            issue0_inst_o  <= NOP;
            issue1_valid_o <= 1'b0;
            issue1_inst_o  <= NOP;
        end else begin
            if (enq) tail <= tail + PTR_W'(2);
            head  <= head + PTR_W'(deq_num);
            count <= count + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq_num);
            if (!stall_i) begin
                issue0_valid_o <= (deq_num != 2'd0);
                issue0_inst_o  <= (deq_num != 2'd0) ? h0 : NOP;
                if (deq_num != 2'd0) issue0_pc_o <= h0_pc;
                issue1_valid_o <= (deq_num == 2'd2);
                issue1_inst_o  <= (deq_num == 2'd2) ? h1 : NOP;
                if (deq_num == 2'd2) issue1_pc_o <= h1_pc;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: reset, pairing, hazards, stall/full/wrap, flush.
module tb_dual_issue_scheduler;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_inst0 = '0;
    logic [31:0] fetch_inst1 = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        v0, v1;
    logic [31:0] inst0, inst1, pc0, pc1;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    dual_issue_scheduler #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fetch_valid), .fetch_inst0_i(fetch_inst0),
        .fetch_inst1_i(fetch_inst1), .fetch_pc_i(fetch_pc),
        .fetch_ready_o(fetch_ready), .stall_i(stall), .flush_i(flush),
        .issue0_valid_o(v0), .issue0_inst_o(inst0), .issue0_pc_o(pc0),
        .issue1_valid_o(v1), .issue1_inst_o(inst1), .issue1_pc_o(pc1),
        .queue_count_o(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        fetch_valid = 1'b1; fetch_inst0 = a; fetch_inst1 = b; fetch_pc = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rst_v0 got %0b exp 0", v0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rst_v1 got %0b exp 0", v1); end
        checks++; if (inst0 !== NOP) begin errors++; $display("FAIL rst_inst0 got %h exp %h", inst0, NOP); end
        checks++; if (inst1 !== NOP) begin errors++; $display("FAIL rst_inst1 got %h exp %h", inst1, NOP); end
        checks++; if (pc0 !== RESET_PC) begin errors++; $display("FAIL rst_pc0 got %h exp %h", pc0, RESET_PC); end
        checks++; if (pc1 !== RESET_PC) begin errors++; $display("FAIL rst_pc1 got %h exp %h", pc1, RESET_PC); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", fetch_ready); end
        step();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL idle_v0 got %0b exp 0", v0); end
    endtask

    task automatic test_independent();
        push(32'h00500093, 32'h00700193, 32'h100);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ind_count_q got %0d exp 2", count); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL ind_nobypass got %0b exp 0", v0); end
        step();
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL ind_v0 got %0b exp 1", v0); end
        checks++; if (inst0 !== 32'h00500093) begin errors++; $display("FAIL ind_inst0 got %h exp 00500093", inst0); end
        checks++; if (pc0 !== 32'h100) begin errors++; $display("FAIL ind_pc0 got %h exp 100", pc0); end
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL ind_v1 got %0b exp 1", v1); end
        checks++; if (inst1 !== 32'h00700193) begin errors++; $display("FAIL ind_inst1 got %h exp 00700193", inst1); end
        checks++; if (pc1 !== 32'h104) begin errors++; $display("FAIL ind_pc1 got %h exp 104", pc1); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ind_count got %0d exp 0", count); end
        step();
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL ind_empty got %0b%0b exp 00", v0, v1); end
        checks++; if (inst0 !== NOP) begin errors++; $display("FAIL ind_empty_inst0 got %h exp %h", inst0, NOP); end
    endtask

    task automatic test_raw();
        push(32'h00500093, 32'h00108113, 32'h200);
        step();
        checks++; if (v0 !== 1'b1 || inst0 !== 32'h00500093) begin errors++; $display("FAIL raw_l0 got %0b/%h exp 1/00500093", v0, inst0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL raw_v1 got %0b exp 0", v1); end
        checks++; if (inst1 !== NOP) begin errors++; $display("FAIL raw_inst1 got %h exp %h", inst1, NOP); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL raw_count got %0d exp 1", count); end
        step();
        checks++; if (v0 !== 1'b1 || inst0 !== 32'h00108113) begin errors++; $display("FAIL raw_second got %0b/%h exp 1/00108113", v0, inst0); end
        checks++; if (pc0 !== 32'h204) begin errors++; $display("FAIL raw_pc0 got %h exp 204", pc0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL raw_second_v1 got %0b exp 0", v1); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL raw_count2 got %0d exp 0", count); end
        step();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL raw_drain got %0b exp 0", v0); end
    endtask

    task automatic test_waw_x0();
        push(32'h123452B7, 32'h00308233, 32'h300);
        step();
        checks++; if (v0 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL lui_add_v got %0b%0b exp 11", v0, v1); end
        checks++; if (inst1 !== 32'h00308233 || pc1 !== 32'h304) begin errors++; $display("FAIL lui_add_l1 got %h/%h exp 00308233/304", inst1, pc1); end
        push(32'h00500093, 32'h00700093, 32'h310);
        step();
        checks++; if (v0 !== 1'b1 || v1 !== 1'b0) begin errors++; $display("FAIL waw_v got %0b%0b exp 10", v0, v1); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL waw_count got %0d exp 1", count); end
        step();
        checks++; if (inst0 !== 32'h00700093 || pc0 !== 32'h314) begin errors++; $display("FAIL waw_second got %h/%h exp 00700093/314", inst0, pc0); end
        push(32'h00500013, 32'h00000033, 32'h320);
        step();
        checks++; if (v0 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL x0_v got %0b%0b exp 11", v0, v1); end
        checks++; if (inst1 !== 32'h00000033 || pc1 !== 32'h324) begin errors++; $display("FAIL x0_l1 got %h/%h exp 00000033/324", inst1, pc1); end
        step();
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL x0_drain got %0b%0b exp 00", v0, v1); end
    endtask

    task automatic test_full_stall_wrap();
        stall = 1'b1;
        push(32'h00100093, 32'h00200113, 32'h400);
        checks++; if (count !== 3'd2 || fetch_ready !== 1'b1) begin errors++; $display("FAIL full_c2 got %0d/%0b exp 2/1", count, fetch_ready); end
        push(32'h00300193, 32'h00400213, 32'h408);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", fetch_ready); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL full_hold got %0b exp 0", v0); end
        push(32'h00500293, 32'h00600313, 32'h410);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject got %0d exp 4", count); end
        stall = 1'b0;
        step();
        checks++; if (v0 !== 1'b1 || inst0 !== 32'h00100093 || pc0 !== 32'h400) begin errors++; $display("FAIL wrap_a0 got %0b/%h/%h exp 1/00100093/400", v0, inst0, pc0); end
        checks++; if (v1 !== 1'b1 || inst1 !== 32'h00200113 || pc1 !== 32'h404) begin errors++; $display("FAIL wrap_a1 got %0b/%h/%h exp 1/00200113/404", v1, inst1, pc1); end
        checks++; if (count !== 3'd2 || fetch_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %0d/%0b exp 2/1", count, fetch_ready); end
        step();
        checks++; if (inst0 !== 32'h00300193 || pc0 !== 32'h408) begin errors++; $display("FAIL wrap_b0 got %h/%h exp 00300193/408", inst0, pc0); end
        checks++; if (inst1 !== 32'h00400213 || pc1 !== 32'h40C) begin errors++; $display("FAIL wrap_b1 got %h/%h exp 00400213/40c", inst1, pc1); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count); end
        step();
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL wrap_drain got %0b%0b exp 00", v0, v1); end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        push(32'h00500093, 32'h00108113, 32'h500);
        stall = 1'b0;
        push(32'h00300193, 32'h00400213, 32'h508);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fl_count3 got %0d exp 3", count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fl_ready3 got %0b exp 0", fetch_ready); end
        checks++; if (v0 !== 1'b1 || v1 !== 1'b0 || inst0 !== 32'h00500093) begin errors++; $display("FAIL fl_issue got %0b%0b/%h exp 10/00500093", v0, v1, inst0); end
        stall = 1'b1;
        step();
        checks++; if (v0 !== 1'b1 || inst0 !== 32'h00500093 || count !== 3'd3) begin errors++; $display("FAIL fl_stall_hold got %0b/%h/%0d exp 1/00500093/3", v0, inst0, count); end
        flush = 1'b1;
        push(32'h00100093, 32'h00200113, 32'h600);
        flush = 1'b0; stall = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", count); end
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL fl_valids got %0b%0b exp 00", v0, v1); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %0b exp 1", fetch_ready); end
        step();
        checks++; if (v0 !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fl_dropped got %0b/%0d exp 0/0", v0, count); end
        stall = 1'b1;
        push(32'h00100093, 32'h00200113, 32'h680);
        flush = 1'b1;
        push(32'h00300193, 32'h00400213, 32'h690);
        flush = 1'b0; stall = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl2_count got %0d exp 0", count); end
        step();
        checks++; if (v0 !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fl2_dropped got %0b/%0d exp 0/0", v0, count); end
        push(32'h00100093, 32'h00200113, 32'h700);
        step();
        checks++; if (v0 !== 1'b1 || inst0 !== 32'h00100093 || pc0 !== 32'h700) begin errors++; $display("FAIL fl_next_l0 got %0b/%h/%h exp 1/00100093/700", v0, inst0, pc0); end
        checks++; if (v1 !== 1'b1 || inst1 !== 32'h00200113 || pc1 !== 32'h704) begin errors++; $display("FAIL fl_next_l1 got %0b/%h/%h exp 1/00200113/704", v1, inst1, pc1); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_next_count got %0d exp 0", count); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_waw_x0();
        test_full_stall_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
